// File: rtl/draw_rect_char_start_pkg.sv
// Shared constants and pixel bundles for the start-screen text overlay.
package draw_rect_char_start_pkg;

    localparam int CHAR_W    = 8;
    localparam int CHAR_H    = 16;
    localparam int TEXT_COLS = 16;
    localparam int TEXT_ROWS = 16;
    localparam int RECT_W    = CHAR_W * TEXT_COLS;
    localparam int RECT_H    = CHAR_H * TEXT_ROWS;

    localparam logic [11:0] START_FONT_COLOR = 12'hf_f_f;

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } vga_t;

    // Everything that must ride alongside the font ROM lookup.
    typedef struct packed {
        vga_t       vga;
        logic       in_rect;
        logic [2:0] bx;
    } pix_t;

endpackage

// File: rtl/draw_rect_char_start_delay.sv
// Generic register delay line, cleared by synchronous reset.
module draw_rect_char_start_delay #(
    parameter int WIDTH   = 8,
    parameter int CLK_DEL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [CLK_DEL-1:0][WIDTH-1:0] pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe <= '0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < CLK_DEL; i++)
                pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[CLK_DEL-1];

endmodule

// File: rtl/draw_rect_char_start.sv
// Start-screen text overlay: cell address out on stage 1, glyph row back on
// stage 2, composited pixel registered on stage 3.
module draw_rect_char_start
    import draw_rect_char_start_pkg::*;
#(
    parameter logic [10:0] X_POS      = 11'd256,
    parameter logic [10:0] Y_POS      = 11'd160,
    parameter logic [11:0] FONT_COLOR = START_FONT_COLOR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [7:0]  char_pixels,
    output logic [7:0]  char_xy,
    output logic [3:0]  char_line,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    logic [6:0] rel_x;
    logic [7:0] rel_y;
    logic       in_rect;
    pix_t       s0, s2;
    logic       paint;

    assign rel_x = 7'(hcount_in - X_POS);
    assign rel_y = 8'(vcount_in - Y_POS);

    // 12-bit compares so X_POS+RECT_W / Y_POS+RECT_H never wrap.
    assign in_rect = ({1'b0, hcount_in} >= {1'b0, X_POS}) &&
                     ({1'b0, hcount_in} <  {1'b0, X_POS} + 12'(RECT_W)) &&
                     ({1'b0, vcount_in} >= {1'b0, Y_POS}) &&
                     ({1'b0, vcount_in} <  {1'b0, Y_POS} + 12'(RECT_H));

    always_ff @(posedge clk) begin
        if (rst || !in_rect) begin
            char_xy   <= '0;
            char_line <= '0;
        end else begin
            char_xy   <= {rel_y[7:4], rel_x[6:3]};
            char_line <= rel_y[3:0];
        end
    end

    always_comb begin
        s0            = '0;
        s0.vga.hcount = hcount_in;
        s0.vga.vcount = vcount_in;
        s0.vga.hsync  = hsync_in;
        s0.vga.vsync  = vsync_in;
        s0.vga.hblnk  = hblnk_in;
        s0.vga.vblnk  = vblnk_in;
        s0.vga.rgb    = rgb_in;
        s0.in_rect    = in_rect;
        s0.bx         = rel_x[2:0];
    end

    // Two stages: one for the table/ROM address, one for the ROM read.
    draw_rect_char_start_delay #(
        .WIDTH   ($bits(pix_t)),
        .CLK_DEL (2)
    ) u_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (s0),
        .dout (s2)
    );

    assign paint = s2.in_rect && !s2.vga.hblnk && !s2.vga.vblnk &&
                   char_pixels[3'd7 - s2.bx];

    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            hcount_out <= s2.vga.hcount;
            vcount_out <= s2.vga.vcount;
            hsync_out  <= s2.vga.hsync;
            vsync_out  <= s2.vga.vsync;
            hblnk_out  <= s2.vga.hblnk;
            vblnk_out  <= s2.vga.vblnk;
            rgb_out    <= paint ? FONT_COLOR : s2.vga.rgb;
        end
    end

endmodule

// File: tb/tb_draw_rect_char_start.sv
// Vector table plus randomized scoreboard run for the start-screen text overlay.
module tb_draw_rect_char_start;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] hcount_in = '0, vcount_in = '0;
    logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
    logic [11:0] rgb_in = '0;
    logic [7:0]  char_pixels = '0;
    logic [7:0]  char_xy;
    logic [3:0]  char_line;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;

    always #5 clk = ~clk;

    draw_rect_char_start dut (
        .clk(clk), .rst(rst),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .char_pixels(char_pixels),
        .char_xy(char_xy), .char_line(char_line),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out)
    );

    typedef struct packed {
        logic [7:0] xy;
        logic [3:0] line;
    } aexp_t;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs, vs, hb, vb;
        logic [11:0] rgb;
    } oexp_t;

    typedef struct {
        logic [10:0] h, v;
        logic        hb, vb;
        logic [11:0] rgb;
        logic        m;
        logic [7:0]  rom;
        logic [7:0]  xy;
        logic [3:0]  line;
        logic [11:0] orgb;
    } tvec_t;

    aexp_t qa[$];
    oexp_t qo[$];
    tvec_t tbl[$];
    int    npass = 0, ntot = 0;
    bit    chk_zero = 0;
    logic       cur_m = 1'b0, last_m = 1'b0;
    logic [7:0] cur_rom = '0, last_rom = '0;

    // Font ROM model: one cycle of latency, constant or address-hashed row.
    function automatic logic [7:0] rom_f(input logic [7:0] xy, input logic [3:0] ln,
                                         input logic m, input logic [7:0] c);
        return m ? ({xy[3:0] ^ xy[7:4], ln} ^ 8'h5a) : c;
    endfunction

    always @(posedge clk) char_pixels <= rom_f(char_xy, char_line, cur_m, cur_rom);

    function automatic void model(input logic [10:0] h, v, input logic hb, vb,
                                  input logic [11:0] rgb, input logic m, input logic [7:0] rom,
                                  output aexp_t ea, output oexp_t eo);
        int x, y, rx, ry;
        bit in, paint;
        logic [7:0] pix;
        x = int'(h); y = int'(v);
        in = (x >= 256) && (x < 384) && (y >= 160) && (y < 416);
        rx = x - 256; ry = y - 160;
        ea.xy   = in ? {4'(ry / 16), 4'(rx / 8)} : 8'h00;
        ea.line = in ? 4'(ry % 16) : 4'd0;
        pix = rom_f(ea.xy, ea.line, m, rom);
        paint = in && !hb && !vb && pix[7 - (rx & 7)];
        eo = '{h: h, v: v, hs: 1'b0, vs: 1'b0, hb: hb, vb: vb,
               rgb: paint ? 12'hfff : rgb};
    endfunction

    task automatic step(input logic [10:0] h, v, input logic hb, vb, input logic [11:0] rgb,
                        input logic m, input logic [7:0] rom, input logic do_rst,
                        input aexp_t ea, input oexp_t eo);
        aexp_t ga, xa;
        oexp_t go, xo;
        @(negedge clk);
        if (chk_zero) begin
            ntot++;
            if ({char_xy, char_line, hcount_out, vcount_out, hsync_out, vsync_out,
                 hblnk_out, vblnk_out, rgb_out} == '0) npass++;
            else $display("FAIL reset_zero: xy=%h line=%h h=%0d v=%0d rgb=%h, required all 0",
                          char_xy, char_line, hcount_out, vcount_out, rgb_out);
        end
        if (qa.size() == 1) begin
            xa = qa.pop_front();
            ga = {char_xy, char_line};
            ntot++;
            if (ga == xa) npass++;
            else $display("FAIL addr: got xy=%h line=%0d, required xy=%h line=%0d",
                          ga.xy, ga.line, xa.xy, xa.line);
        end
        if (qo.size() == 3) begin
            xo = qo.pop_front();
            go = {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out};
            ntot++;
            if (go == xo) npass++;
            else $display("FAIL out: got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b rgb=%h, required h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b rgb=%h",
                          go.h, go.v, go.hs, go.vs, go.hb, go.vb, go.rgb,
                          xo.h, xo.v, xo.hs, xo.vs, xo.hb, xo.vb, xo.rgb);
        end
        hcount_in = h; vcount_in = v; hblnk_in = hb; vblnk_in = vb; rgb_in = rgb;
        hsync_in = 1'($urandom); vsync_in = 1'($urandom);
        cur_m = m; cur_rom = rom;
        rst = do_rst;
        if (do_rst) begin
            qa.delete(); qo.delete();
            chk_zero = 1;
        end else begin
            chk_zero = 0;
            eo.hs = hsync_in; eo.vs = vsync_in;
            qa.push_back(ea);
            qo.push_back(eo);
        end
    endtask

    // An idle pixel absorbs the ROM read that straddles a ROM-mode change.
    task automatic apply(input logic [10:0] h, v, input logic hb, vb, input logic [11:0] rgb,
                         input logic m, input logic [7:0] rom, input aexp_t ea, input oexp_t eo);
        aexp_t ia;
        oexp_t io;
        if (m != last_m || rom != last_rom) begin
            model(11'd0, 11'd0, 1'b0, 1'b0, 12'h000, last_m, last_rom, ia, io);
            step(11'd0, 11'd0, 1'b0, 1'b0, 12'h000, last_m, last_rom, 1'b0, ia, io);
            last_m = m; last_rom = rom;
        end
        step(h, v, hb, vb, rgb, m, rom, 1'b0, ea, eo);
    endtask

    task automatic add(input logic [10:0] h, v, input logic hb, vb, input logic [11:0] rgb,
                       input logic [7:0] rom, input logic [7:0] xy, input logic [3:0] line,
                       input logic [11:0] orgb);
        tvec_t t;
        t.h = h; t.v = v; t.hb = hb; t.vb = vb; t.rgb = rgb; t.m = 1'b0; t.rom = rom;
        t.xy = xy; t.line = line; t.orgb = orgb;
        tbl.push_back(t);
    endtask

    initial begin
        aexp_t ea;
        oexp_t eo;
        logic [10:0] rh, rv;
        logic rhb, rvb;

        // Address mapping, glyph sweep, edges, blanking, wrap.
        add(11'd299, 11'd199, 0, 0, 12'habc, 8'h81, 8'h25, 4'd7, 12'habc);
        for (int i = 0; i < 8; i++)
            add(11'(256 + i), 11'd160, 0, 0, 12'h123, 8'h81, 8'h00, 4'd0,
                (i == 0 || i == 7) ? 12'hfff : 12'h123);
        add(11'd255,  11'd200, 0, 0, 12'h456, 8'hff, 8'h00, 4'd0,  12'h456);
        add(11'd384,  11'd200, 0, 0, 12'h457, 8'hff, 8'h00, 4'd0,  12'h457);
        add(11'd300,  11'd159, 0, 0, 12'h458, 8'hff, 8'h00, 4'd0,  12'h458);
        add(11'd300,  11'd416, 0, 0, 12'h459, 8'hff, 8'h00, 4'd0,  12'h459);
        add(11'd383,  11'd415, 0, 0, 12'h789, 8'hff, 8'hff, 4'd15, 12'hfff);
        add(11'd256,  11'd160, 0, 0, 12'h321, 8'hff, 8'h00, 4'd0,  12'hfff);
        add(11'd300,  11'd200, 1, 0, 12'h555, 8'hff, 8'h25, 4'd8,  12'h555);
        add(11'd300,  11'd200, 0, 1, 12'h666, 8'hff, 8'h25, 4'd8,  12'h666);
        add(11'd300,  11'd200, 0, 0, 12'h777, 8'hff, 8'h25, 4'd8,  12'hfff);
        add(11'd2047, 11'd2047, 0, 0, 12'h888, 8'hff, 8'h00, 4'd0, 12'h888);
        add(11'd0,    11'd0,   0, 0, 12'h999, 8'hff, 8'h00, 4'd0,  12'h999);
        add(11'd300,  11'd200, 0, 0, 12'h777, 8'h00, 8'h25, 4'd8,  12'h777);

        // Reset with random inputs: outputs must read zero.
        for (int i = 0; i < 4; i++)
            step(11'($urandom), 11'($urandom), 1'($urandom), 1'($urandom), 12'($urandom),
                 1'b0, 8'h00, 1'b1, '0, '0);

        foreach (tbl[i]) begin
            ea = '{xy: tbl[i].xy, line: tbl[i].line};
            eo = '{h: tbl[i].h, v: tbl[i].v, hs: 1'b0, vs: 1'b0,
                   hb: tbl[i].hb, vb: tbl[i].vb, rgb: tbl[i].orgb};
            apply(tbl[i].h, tbl[i].v, tbl[i].hb, tbl[i].vb, tbl[i].rgb,
                  tbl[i].m, tbl[i].rom, ea, eo);
        end

        // Random pixels around the rectangle with an address-dependent ROM,
        // including a mid-stream reset.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                step(11'd300, 11'd200, 1'b0, 1'b0, 12'h0f0, 1'b1, 8'h00, 1'b1, '0, '0);
            end else begin
                rh = (i % 16 == 0) ? 11'($urandom) : 11'($urandom_range(240, 400));
                rv = (i % 16 == 1) ? 11'($urandom) : 11'($urandom_range(140, 430));
                rhb = ($urandom_range(0, 7) == 0);
                rvb = ($urandom_range(0, 7) == 0);
                model(rh, rv, rhb, rvb, 12'(i * 37), 1'b1, 8'h00, ea, eo);
                apply(rh, rv, rhb, rvb, 12'(i * 37), 1'b1, 8'h00, ea, eo);
            end
        end

        // Drain the pipeline.
        for (int i = 0; i < 4; i++) begin
            model(11'd0, 11'd0, 1'b0, 1'b0, 12'h000, 1'b1, 8'h00, ea, eo);
            apply(11'd0, 11'd0, 1'b0, 1'b0, 12'h000, 1'b1, 8'h00, ea, eo);
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/draw_rect_char_start.md
Name: draw_rect_char_start

Overview:
- Start-screen text overlay stage in the VGA pixel pipeline.
- Maps the incoming pixel position onto a 16x16 character grid and drives that cell's address to the start-screen character table (char_xy -> char_code).
- The char_code indexes the synchronous font ROM together with char_line; the block receives the returned 8-pixel glyph row and paints glyph pixels in FONT_COLOR over the incoming RGB, with all timing signals delayed to match.

Parameters:
- X_POS, 11'd256, left edge of the text rectangle in pixels.
- Y_POS, 11'd160, top edge of the text rectangle in pixels.
- FONT_COLOR, 12'hf_f_f, 4:4:4 RGB colour of glyph pixels.
- CHAR_W, 8 (fixed), glyph width in pixels.
- CHAR_H, 16 (fixed), glyph height in pixels.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- hcount_in  in  11  pixel column
- vcount_in  in  11  pixel row
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  timing
- rgb_in  in  12  background colour
- char_pixels  in  8  font ROM glyph row; bit 7 is the leftmost pixel
- char_xy  out  8  {row[3:0], col[3:0]} to the character table
- char_line  out  4  glyph row index to the font ROM
- hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out  out  11/11/1/1/1/1  delayed timing
- rgb_out  out  12  composited colour

Behaviour:
- Clocking and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: all outputs 0. Internal pipeline registers are 0, including in_rect flags.
- Rectangle test: rel_x = hcount_in - X_POS and rel_y = vcount_in - Y_POS, both 11-bit unsigned.
  - in_rect = hcount_in >= X_POS && hcount_in < X_POS+128 && vcount_in >= Y_POS && vcount_in < Y_POS+256.
  - Compare at 12 bits so X_POS+128 cannot wrap.
- Stage 1 (register):
  - char_xy <= {rel_y[7:4], rel_x[6:3]}.
  - char_line <= rel_y[3:0].
  - Capture bit index bx1 = rel_x[2:0], in_rect1, and the timing/rgb inputs.
  - When in_rect is 0: char_xy <= 0 and char_line <= 0.
- Stage 2 (register):
  - The character table is combinational and the font ROM is registered, so char_pixels is valid in the cycle after char_xy/char_line.
  - Delay bx, in_rect, timing and rgb one more cycle (bx2, in_rect2, and so on).
- Stage 3 (output register):
  - rgb_out <= (in_rect2 && !hblnk2 && !vblnk2 && char_pixels[7-bx2]) ? FONT_COLOR : rgb2.
  - Timing outputs <= stage-2 copies.
- Latency: every output except char_xy/char_line appears exactly 3 clk after its input. char_xy/char_line are 1 clk after input.
- Blanking: during hblnk or vblnk, rgb passes through unchanged and no glyph is drawn.
- Boundaries:
  - The last column of the rectangle is X_POS+127 (col 15, bit 7-7 = 0).
  - The last row is Y_POS+255 (row 15, line 15).
  - Pixels at X_POS-1 and at X_POS+128 are never painted.
- Frame wrap: hcount/vcount wrap to 0 with no special handling; the pipeline is stateless across frames.
- Reset mid-frame: all stages clear the same cycle. Output resumes correct compositing 3 clk after rst falls.

Decomposition:
- vga_pkg gains CHAR_W=8, CHAR_H=16, TEXT_COLS=16, TEXT_ROWS=16 and the default start-screen FONT_COLOR.
- The 3-stage timing/rgb delay is a generic sub-module, delay (params WIDTH, CLK_DEL), instantiated with CLK_DEL=2 for the timing/rgb bundle plus in_rect/bx.
- The stage-3 output register stays in this block.

Test Plan:
- Reset and idle: assert rst for 4 clk with random inputs -> all outputs 0. After release, outputs equal inputs delayed 3 clk wherever in_rect=0.
- Address mapping: X_POS=256, Y_POS=160; drive hcount=256+8*5+3=299, vcount=160+16*2+7=199 -> one clk later char_xy=8'h25, char_line=4'd7.
- Glyph paint: model font ROM 1-cycle latency returning 8'b1000_0001 for all addresses; sweep hcount 256..263 on vcount 160, rgb_in=12'h123.
  - rgb_out = FONT_COLOR at 256 and 263, 12'h123 at 257..262, each 3 clk after input.
- Edges: hcount=255 and 384, vcount=159 and 416 with char_pixels=8'hff -> rgb_out=rgb_in, char_xy=0, char_line=0.
- Blanking: in-rect pixel with hblnk_in=1 and char_pixels=8'hff -> rgb_out=rgb_in; hblnk_out=1 exactly 3 clk later.
- Full frame: run 800x600 timing with the real character table and font ROM -> "PLAY AGAIN" rendered starting at col 3, row 0, with no off-by-one columns; compare against a golden frame dump.
